// File: rtl/serial_ck_tx.sv
// Multi-lane serial clock/data transmitter: lead, then ncyc sck pulses with MSB-first data per lane.
// Optional receive path (sdi/dout) enabled by defining SERIAL_CK_TX_SDI_EN.
module serial_ck_tx #(
  parameter int   DW       = 32,
  parameter int   N_CH     = 1,
  parameter int   CW       = 32,
  parameter logic P_Y_INIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 y0,
  input  logic [7:0]           ncyc,
  input  logic [CW-1:0]        n0,
  input  logic [CW-1:0]        n1,
  input  logic [CW-1:0]        n2,
  input  logic [N_CH*DW-1:0]   din,
`ifdef SERIAL_CK_TX_SDI_EN
  input  logic [N_CH-1:0]      sdi,
  output logic [N_CH*DW-1:0]   dout,
`endif
  output logic                 sck,
  output logic [N_CH-1:0]      sdo,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_HI, S_LO} state_t;

  localparam logic [CW-1:0] ONE_CW = CW'(1);
  localparam logic [7:0]    DW_B   = 8'(DW);

  state_t                    r_state;
  logic                      r_sck;
  logic [N_CH-1:0]           r_sdo;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_y0;
  logic [7:0]                r_ncyc;
  logic [CW-1:0]             r_n1;
  logic [CW-1:0]             r_n2;
  logic [CW-1:0]             r_cnt;
  logic [7:0]                r_bit;
  logic [N_CH-1:0][DW-1:0]   r_sh;

  logic [CW-1:0]             w_n0;
  logic [CW-1:0]             w_n1;
  logic [CW-1:0]             w_n2;
  logic [7:0]                w_ncyc;
  logic                      w_exp;
  logic                      w_last;
  logic [N_CH-1:0][DW-1:0]   w_aligned;

  assign w_n0   = (n0 == '0) ? ONE_CW : n0;
  assign w_n1   = (n1 == '0) ? ONE_CW : n1;
  assign w_n2   = (n2 == '0) ? ONE_CW : n2;
  assign w_ncyc = (ncyc == 8'd0) ? 8'd1 : ((ncyc > DW_B) ? DW_B : ncyc);
  assign w_exp  = (r_cnt <= ONE_CW);
  assign w_last = (r_bit == (r_ncyc - 8'd1));

  assign sck  = r_sck;
  assign sdo  = r_sdo;
  assign busy = r_busy;
  assign done = r_done;

  // Left-align each lane so bit ncyc-1 sits at the MSB of the shift register.
  always_comb begin
    w_aligned = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_aligned[k] = din[k*DW +: DW] << (DW_B - w_ncyc);
    end
  end

  // Transfer sequencer: phase timing, sck generation, data shifting and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sck   <= P_Y_INIT;
      r_sdo   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y0    <= P_Y_INIT;
      r_ncyc  <= 8'd1;
      r_n1    <= '0;
      r_n2    <= '0;
      r_cnt   <= '0;
      r_bit   <= 8'd0;
      r_sh    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sck <= y0;
          if (start) begin
            r_y0    <= y0;
            r_ncyc  <= w_ncyc;
            r_n1    <= w_n1;
            r_n2    <= w_n2;
            r_cnt   <= w_n0;
            r_bit   <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= S_LEAD;
            for (int k = 0; k < N_CH; k++) begin
              r_sdo[k] <= w_aligned[k][DW-1];
              r_sh[k]  <= w_aligned[k] << 8'd1;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_LEAD: begin
          if (w_exp) begin
            r_sck   <= ~r_y0;
            r_cnt   <= r_n1;
            r_state <= S_HI;
          end else begin
            r_cnt <= r_cnt - ONE_CW;
          end
        end
        S_HI: begin
          if (w_exp) begin
            r_sck   <= r_y0;
            r_cnt   <= r_n2;
            r_state <= S_LO;
          end else begin
            r_cnt <= r_cnt - ONE_CW;
          end
        end
        S_LO: begin
          if (w_exp) begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_sdo   <= '0;
            end else begin
              // Data only moves on LO->HI so it is stable across each full bit period.
              r_sck   <= ~r_y0;
              r_cnt   <= r_n1;
              r_bit   <= r_bit + 8'd1;
              r_state <= S_HI;
              for (int k = 0; k < N_CH; k++) begin
                r_sdo[k] <= r_sh[k][DW-1];
                r_sh[k]  <= r_sh[k] << 8'd1;
              end
            end
          end else begin
            r_cnt <= r_cnt - ONE_CW;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sck   <= P_Y_INIT;
          r_sdo   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_CK_TX_SDI_EN
  logic [N_CH-1:0][DW-1:0] r_rx;
  logic [N_CH-1:0][DW-1:0] r_dout;

  assign dout = r_dout;

  // Receive capture: sample sdi at each HI->LO edge, publish on the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx   <= '0;
      r_dout <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_rx <= '0;
      end else if ((r_state == S_HI) && w_exp) begin
        for (int k = 0; k < N_CH; k++) begin
          r_rx[k] <= (r_rx[k] << 8'd1) | DW'(sdi[k]);
        end
      end
      if ((r_state == S_LO) && w_exp && w_last) begin
        r_dout <= r_rx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_ck_tx.sv
// Directed self-checking bench for serial_ck_tx (DW=8, N_CH=2, P_Y_INIT=1).
module tb_serial_ck_tx;
  localparam int   DW   = 8;
  localparam int   N_CH = 2;
  localparam int   CW   = 16;
  localparam logic PY   = 1'b1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                y0;
  logic [7:0]          ncyc;
  logic [CW-1:0]       n0, n1, n2;
  logic [N_CH*DW-1:0]  din;
  logic                sck;
  logic [N_CH-1:0]     sdo;
  logic                busy;
  logic                done;
`ifdef SERIAL_CK_TX_SDI_EN
  logic [N_CH-1:0]     sdi;
  logic [N_CH*DW-1:0]  dout;
  assign sdi = sdo;
`endif

  serial_ck_tx #(.DW(DW), .N_CH(N_CH), .CW(CW), .P_Y_INIT(PY)) dut (
    .clk(clk), .rst(rst), .start(start), .y0(y0), .ncyc(ncyc),
    .n0(n0), .n1(n1), .n2(n2), .din(din),
`ifdef SERIAL_CK_TX_SDI_EN
    .sdi(sdi), .dout(dout),
`endif
    .sck(sck), .sdo(sdo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int busy_cnt, pulse_cnt, hi_cnt, lead_cnt, done_cnt, unstable;
  logic [7:0] bits0, bits1;
  logic end_sck, end_busy, fin;
  logic [N_CH-1:0] end_sdo;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one transfer and observe it cycle by cycle up to and including the done cycle.
  task automatic run(input logic y, input logic [7:0] nc, input logic [CW-1:0] a,
                     input logic [CW-1:0] b, input logic [CW-1:0] c,
                     input logic [N_CH*DW-1:0] d, input logic hold);
    logic prev, seen;
    logic [N_CH-1:0] cur;
    y0 = y; ncyc = nc; n0 = a; n1 = b; n2 = c; din = d; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    busy_cnt = 0; pulse_cnt = 0; hi_cnt = 0; lead_cnt = 0; done_cnt = 0; unstable = 0;
    bits0 = 8'd0; bits1 = 8'd0; fin = 1'b0; prev = y; seen = 1'b0; cur = '0;
    end_sck = 1'b0; end_busy = 1'b0; end_sdo = '0;
    for (int i = 0; i < 1000 && !fin; i++) begin
      if (busy) busy_cnt++;
      if (busy && !seen && sck === y) lead_cnt++;
      if (sck === ~y) begin
        hi_cnt++;
        if (prev === y) begin
          pulse_cnt++;
          seen  = 1'b1;
          bits0 = {bits0[6:0], sdo[0]};
          bits1 = {bits1[6:0], sdo[1]};
          cur   = sdo;
        end
      end
      if (seen && busy && sdo !== cur) unstable++;
      if (done) begin
        done_cnt++; fin = 1'b1; end_sck = sck; end_sdo = sdo; end_busy = busy;
      end
      prev = sck;
      if (!fin) tick();
    end
    chk_eq("no_timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; y0 = 1'b0; ncyc = 8'd0;
    n0 = '0; n1 = '0; n2 = '0; din = '0;
    tick(); tick();
    chk_eq("rst_sck", 32'(sck), 32'(PY));
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_sdo", 32'(sdo), 32'd0);
    rst = 1'b0;
    tick();
    chk_eq("idle_follow_y0", 32'(sck), 32'd0);

    // Basic transfer
    run(1'b0, 8'd8, 16'd3, 16'd2, 16'd2, {8'h00, 8'hA5}, 1'b0);
    chk_eq("basic_busy", busy_cnt, 35);
    chk_eq("basic_lead", lead_cnt, 3);
    chk_eq("basic_pulses", pulse_cnt, 8);
    chk_eq("basic_hi", hi_cnt, 16);
    chk_eq("basic_bits", 32'(bits0), 32'hA5);
    chk_eq("basic_stable", unstable, 0);
    chk_eq("basic_end_sck", 32'(end_sck), 32'd0);
    chk_eq("basic_end_sdo", 32'(end_sdo), 32'd0);
    chk_eq("basic_end_busy", 32'(end_busy), 32'd0);
    tick();
    chk_eq("basic_done_once", 32'(done), 32'd0);
    tick();

    // Zero clamp
    run(1'b1, 8'd0, 16'd0, 16'd0, 16'd0, {8'h00, 8'h01}, 1'b0);
    chk_eq("zero_busy", busy_cnt, 3);
    chk_eq("zero_lead", lead_cnt, 1);
    chk_eq("zero_pulses", pulse_cnt, 1);
    chk_eq("zero_hi", hi_cnt, 1);
    chk_eq("zero_bits", 32'(bits0), 32'h01);
    chk_eq("zero_end_sck", 32'(end_sck), 32'd1);
    tick();
    chk_eq("zero_done_once", 32'(done), 32'd0);
    tick();

    // Oversize ncyc
    run(1'b0, 8'd200, 16'd1, 16'd1, 16'd1, {8'h00, 8'hFF}, 1'b0);
    chk_eq("over_busy", busy_cnt, 17);
    chk_eq("over_pulses", pulse_cnt, 8);
    chk_eq("over_bits0", 32'(bits0), 32'hFF);
    chk_eq("over_bits1", 32'(bits1), 32'h00);
    tick(); tick();

    // Multi-lane
    run(1'b0, 8'd8, 16'd2, 16'd1, 16'd3, {8'h0F, 8'hF0}, 1'b0);
    chk_eq("multi_busy", busy_cnt, 34);
    chk_eq("multi_bits0", 32'(bits0), 32'hF0);
    chk_eq("multi_bits1", 32'(bits1), 32'h0F);
    chk_eq("multi_stable", unstable, 0);
    tick(); tick();

    // Short ncyc (also the loopback vector)
    run(1'b0, 8'd5, 16'd1, 16'd1, 16'd2, {8'hE9, 8'h16}, 1'b0);
    chk_eq("short_busy", busy_cnt, 16);
    chk_eq("short_pulses", pulse_cnt, 5);
    chk_eq("short_bits0", 32'(bits0), 32'h16);
    chk_eq("short_bits1", 32'(bits1), 32'h09);
`ifdef SERIAL_CK_TX_SDI_EN
    chk_eq("loop_dout_done", 32'(dout), 32'h0916);
    tick(); tick(); tick();
    chk_eq("loop_dout_hold", 32'(dout), 32'h0916);
`endif
    tick(); tick();

    // Handshake: start held through the transfer, still high in the done cycle
    run(1'b1, 8'd2, 16'd1, 16'd1, 16'd1, {8'h00, 8'h03}, 1'b1);
    chk_eq("hold_busy", busy_cnt, 5);
    chk_eq("hold_pulses", pulse_cnt, 2);
    chk_eq("hold_bits", 32'(bits0), 32'h03);
    chk_eq("hold_gap_idle", 32'(end_busy), 32'd0);
    tick();
    chk_eq("b2b_busy", 32'(busy), 32'd1);
    chk_eq("b2b_lead_sck", 32'(sck), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 20 && sck !== 1'b0; i++) tick();
    chk_eq("reach_hi", 32'(sck), 32'd0);
    rst = 1'b1;
    tick();
    chk_eq("abort_sck", 32'(sck), 32'(PY));
    chk_eq("abort_busy", 32'(busy), 32'd0);
    chk_eq("abort_done", 32'(done), 32'd0);
    chk_eq("abort_sdo", 32'(sdo), 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk_eq("abort_no_done", done_cnt, 0);
    chk_eq("abort_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
